// File: rtl/serial_mag_compare_ctrl.sv
// Bit-serial MSB-first magnitude comparison sequencer around a shared 1-bit comparator cell.
// Handles the start/busy/done handshake, abort, and flags a cell response that is not one-hot.
module serial_mag_compare_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             cmp_a,
  output logic             cmp_b,
  input  logic             cmp_gt,
  input  logic             cmp_eq,
  input  logic             cmp_lt,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic             err,
  output logic [CW-1:0]    bit_count
);

  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} ctrlState;

  ctrlState         state, stateNext;
  logic [WIDTH-1:0] aReg, aNext, bReg, bNext;
  logic [IW-1:0]    idx, idxNext;
  logic             busyNext, doneNext, gtNext, eqNext, ltNext, errNext;
  logic [CW-1:0]    bitCountNext;

  // State and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      aReg      <= '0;
      bReg      <= '0;
      idx       <= IW'(WIDTH - 1);
      busy      <= 1'b0;
      done      <= 1'b0;
      gt        <= 1'b0;
      eq        <= 1'b0;
      lt        <= 1'b0;
      err       <= 1'b0;
      bit_count <= '0;
    end else begin
      state     <= stateNext;
      aReg      <= aNext;
      bReg      <= bNext;
      idx       <= idxNext;
      busy      <= busyNext;
      done      <= doneNext;
      gt        <= gtNext;
      eq        <= eqNext;
      lt        <= ltNext;
      err       <= errNext;
      bit_count <= bitCountNext;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    stateNext    = state;
    aNext        = aReg;
    bNext        = bReg;
    idxNext      = idx;
    busyNext     = busy;
    doneNext     = 1'b0;
    gtNext       = gt;
    eqNext       = eq;
    ltNext       = lt;
    errNext      = err;
    bitCountNext = bit_count;

    case (state)
      IDLE: begin
        if (start) begin
          aNext        = a_in;
          bNext        = b_in;
          idxNext      = IW'(WIDTH - 1);
          gtNext       = 1'b0;
          eqNext       = 1'b0;
          ltNext       = 1'b0;
          errNext      = 1'b0;
          bitCountNext = '0;
          busyNext     = 1'b1;
          stateNext    = SCAN;
        end
      end

      SCAN: begin
        if (abort) begin
          // Abort wins over any termination the cell reports on the same edge
          stateNext    = IDLE;
          busyNext     = 1'b0;
          gtNext       = 1'b0;
          eqNext       = 1'b0;
          ltNext       = 1'b0;
          errNext      = 1'b0;
          bitCountNext = '0;
          idxNext      = IW'(WIDTH - 1);
        end else begin
          bitCountNext = bit_count + CW'(1);
          case ({cmp_gt, cmp_eq, cmp_lt})
            3'b100, 3'b001: begin
              gtNext    = cmp_gt;
              ltNext    = cmp_lt;
              busyNext  = 1'b0;
              doneNext  = 1'b1;
              stateNext = DONE;
            end
            3'b010: begin
              if (idx == '0) begin
                eqNext    = 1'b1;
                busyNext  = 1'b0;
                doneNext  = 1'b1;
                stateNext = DONE;
              end else begin
                idxNext = idx - IW'(1);
              end
            end
            default: begin
              errNext   = 1'b1;
              gtNext    = 1'b0;
              eqNext    = 1'b0;
              ltNext    = 1'b0;
              busyNext  = 1'b0;
              doneNext  = 1'b1;
              stateNext = DONE;
            end
          endcase
        end
      end

      DONE: begin
        stateNext = IDLE;
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Cell operands are driven only while scanning
  assign cmp_a = (state == SCAN) ? aReg[idx] : 1'b0;
  assign cmp_b = (state == SCAN) ? bReg[idx] : 1'b0;

endmodule

// File: tb/tb_serial_mag_compare_ctrl.sv
// Self-checking bench for serial_mag_compare_ctrl: directed scenarios plus random operands
// checked against an arithmetic reference model of the word comparison.
module tb_serial_mag_compare_ctrl;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CW    = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cmp_a;
  logic             cmp_b;
  logic             cmp_gt;
  logic             cmp_eq;
  logic             cmp_lt;
  logic             busy;
  logic             done;
  logic             gt;
  logic             eq;
  logic             lt;
  logic             err;
  logic [CW-1:0]    bit_count;
  logic             faultOn;

  int total = 0;
  int bad   = 0;

  serial_mag_compare_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .a_in(a_in), .b_in(b_in), .cmp_a(cmp_a), .cmp_b(cmp_b),
    .cmp_gt(cmp_gt), .cmp_eq(cmp_eq), .cmp_lt(cmp_lt),
    .busy(busy), .done(done), .gt(gt), .eq(eq), .lt(lt),
    .err(err), .bit_count(bit_count)
  );

  always #5 clk = ~clk;

  // Comparator cell; the fault makes it answer both gt and lt
  assign cmp_gt = faultOn ? 1'b1 : (cmp_a & ~cmp_b);
  assign cmp_eq = faultOn ? 1'b0 : ~(cmp_a ^ cmp_b);
  assign cmp_lt = faultOn ? 1'b1 : (~cmp_a & cmp_b);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Word-level expectation: ordering by plain arithmetic, n from the top differing bit
  task automatic refModel(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          output logic eGt, output logic eEq, output logic eLt,
                          output int n);
    logic [WIDTH-1:0] x;
    eGt = (a > b);
    eEq = (a == b);
    eLt = (a < b);
    x = a ^ b;
    n = WIDTH;
    for (int i = 0; i < WIDTH; i++) begin
      if (x[i]) n = WIDTH - i;
    end
  endtask

  task automatic runCompare(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic withAbort, input string tag);
    logic eGt, eEq, eLt;
    int   n;
    int   cyc;
    refModel(a, b, eGt, eEq, eLt, n);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    abort = withAbort;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk({tag, "_busy0"}, 32'(busy), 32'd1);
    chk({tag, "_clr"}, 32'({gt, eq, lt, err}), 32'd0);
    chk({tag, "_cnt0"}, 32'(bit_count), 32'd0);
    cyc = 0;
    while (done !== 1'b1 && cyc < WIDTH + 2) begin
      if (cyc < WIDTH) begin
        chk({tag, "_cmpa"}, 32'(cmp_a), 32'(a[WIDTH-1-cyc]));
        chk({tag, "_cmpb"}, 32'(cmp_b), 32'(b[WIDTH-1-cyc]));
      end
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      tick();
      cyc++;
    end
    chk({tag, "_lat"}, 32'(cyc), 32'(n));
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busyend"}, 32'(busy), 32'd0);
    chk({tag, "_res"}, 32'({gt, eq, lt, err}), 32'({eGt, eEq, eLt, 1'b0}));
    chk({tag, "_cnt"}, 32'(bit_count), 32'(n));
    tick();
    chk({tag, "_pulse"}, 32'(done), 32'd0);
    chk({tag, "_hold"}, 32'({gt, eq, lt}), 32'({eGt, eEq, eLt}));
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    rst_n   = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    a_in    = '0;
    b_in    = '0;
    faultOn = 1'b0;
    tick();
    tick();
    chk("rst_outs", 32'({busy, done, gt, eq, lt, err}), 32'd0);
    chk("rst_cnt", 32'(bit_count), 32'd0);
    chk("rst_cmp", 32'({cmp_a, cmp_b}), 32'd0);
    rst_n = 1'b1;
    tick();

    // Equal, early difference, late difference
    runCompare(8'hA5, 8'hA5, 1'b0, "t1");
    runCompare(8'h80, 8'h7F, 1'b0, "t2");
    runCompare(8'h12, 8'h13, 1'b0, "t3");

    // Requests while scanning and during DONE are dropped; abort in DONE is harmless
    a_in = 8'h40; b_in = 8'h00; start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    chk("t4_busy", 32'(busy), 32'd1);
    chk("t4_nodone", 32'(done), 32'd0);
    tick();
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_gt", 32'({gt, eq, lt}), 32'b100);
    chk("t4_cnt", 32'(bit_count), 32'd2);
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("t4_pulse", 32'(done), 32'd0);
    chk("t4_idle", 32'(busy), 32'd0);
    chk("t4_hold", 32'({gt, eq, lt}), 32'b100);
    tick();
    chk("t4_dropped", 32'({busy, done}), 32'd0);

    // Abort at the third scan edge
    a_in = 8'h01; b_in = 8'h00; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_res", 32'({done, gt, eq, lt, err}), 32'd0);
    chk("t5_cnt", 32'(bit_count), 32'd0);
    chk("t5_cmp", 32'({cmp_a, cmp_b}), 32'd0);
    for (int i = 0; i < WIDTH + 2; i++) begin
      chk("t5_nodone", 32'(done), 32'd0);
      tick();
    end
    runCompare(8'h01, 8'h00, 1'b0, "t5b");

    // Non-one-hot cell answer at bit 5
    a_in = 8'h3C; b_in = 8'h3C; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("t6_cmpa5", 32'(cmp_a), 32'd1);
    faultOn = 1'b1;
    tick();
    faultOn = 1'b0;
    chk("t6_done", 32'(done), 32'd1);
    chk("t6_err", 32'(err), 32'd1);
    chk("t6_res", 32'({gt, eq, lt}), 32'd0);
    chk("t6_cnt", 32'(bit_count), 32'd3);
    tick();
    chk("t6_pulse", 32'(done), 32'd0);
    chk("t6_errhold", 32'(err), 32'd1);

    // Reset mid-scan
    a_in = 8'hFF; b_in = 8'hFF; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("t7_cnt_pre", 32'(bit_count), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("t7_outs", 32'({busy, done, gt, eq, lt, err}), 32'd0);
    chk("t7_cnt", 32'(bit_count), 32'd0);
    chk("t7_cmp", 32'({cmp_a, cmp_b}), 32'd0);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < WIDTH + 2; i++) begin
      chk("t7_nodone", 32'(done), 32'd0);
      tick();
    end

    // Random operands; abort alongside start in IDLE must not block acceptance
    for (int i = 0; i < 40; i++) begin
      ra = WIDTH'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : WIDTH'($urandom);
      runCompare(ra, rb, 1'($urandom_range(0, 1)), "rnd");
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
